// File: rtl/lap_recall_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : lap_recall_ctrl_pkg
// Brief   : Shared state encoding and default sizes for the lap recall block.
// Revision: 1.0
// ----------------------------------------------------------------------------
package lap_recall_ctrl_pkg;

    typedef enum logic [1:0] {
        LIVE   = 2'b00,
        HOLD   = 2'b01,
        RECALL = 2'b10
    } lap_state_t;

    localparam int c_time_w   = 20;
    localparam int c_depth    = 8;
    localparam int c_aw       = 3;
    localparam int c_hold_cyc = 16;

endpackage

`default_nettype wire

// File: rtl/lap_recall_ctrl_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : lap_regfile
// Brief   : DEPTH x TIME_W storage, one synchronous write, one async read.
// Revision: 1.0
// ----------------------------------------------------------------------------
module lap_regfile #(
    parameter int TIME_W = 20,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [TIME_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [TIME_W-1:0] rd_data
);

    logic [TIME_W-1:0] r_mem [DEPTH];

    // Contents are deliberately left unreset; validity is tracked by lap_count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (wr_en && (wr_addr == AW'(gi))) begin
                r_mem[gi] <= wr_data;
            end
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/lap_recall_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : lap_recall_ctrl
// Brief   : Lap capture buffer and display source scheduler (live/hold/recall).
// Revision: 1.0
// ----------------------------------------------------------------------------
module lap_recall_ctrl
    import lap_recall_ctrl_pkg::*;
#(
    parameter int TIME_W   = c_time_w,
    parameter int DEPTH    = c_depth,
    parameter int AW       = c_aw,
    parameter int HOLD_CYC = c_hold_cyc
) (
    input  logic              clk,
    input  logic              state_reset,
    input  logic              rst,
    input  logic              clken,
    input  logic              mode,
    input  logic              lap_trigger,
    input  logic              recall_btn,
    input  logic [TIME_W-1:0] time_in,
    output logic [TIME_W-1:0] disp_data,
    output logic              disp_sel,
    output logic [AW-1:0]     lap_idx,
    output logic [AW:0]       lap_count,
    output logic              full
);

    localparam int              c_hw        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [AW:0]     c_cnt_last  = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0]   c_idx_last  = AW'(DEPTH - 1);
    localparam logic [c_hw-1:0] c_hold_load = c_hw'(HOLD_CYC - 1);

    lap_state_t        r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_base;
    logic [AW:0]       r_lap_count;
    logic [c_hw-1:0]   r_hold_cnt;
    logic [TIME_W-1:0] r_disp_data;
    logic              r_disp_sel;
    logic [AW-1:0]     r_lap_idx;
    logic              r_full;
    logic              r_recall_d;

    logic              w_capture;
    logic              w_recall_edge;
    logic              w_recall_go;
    logic              w_idx_is_last;
    logic [AW-1:0]     w_newest_idx;
    logic [AW-1:0]     w_step_idx;
    logic [AW-1:0]     w_rd_addr;
    logic [TIME_W-1:0] w_rd_data;

    // Sync clear blocks the write so rst dominates every other input.
    assign w_capture     = lap_trigger & clken & ~mode & ~rst & (r_state != RECALL);
    assign w_recall_edge = recall_btn & ~r_recall_d;
    assign w_recall_go   = w_recall_edge & ~clken & ~mode & (r_lap_count != '0);
    assign w_idx_is_last = ({1'b0, r_lap_idx} == (r_lap_count - 1'b1));

    // After a capture the newest lap sits at the top of the valid window.
    assign w_newest_idx  = r_full ? c_idx_last : r_lap_count[AW-1:0];

    // In RECALL the port pre-fetches the next lap; from LIVE it fetches the oldest.
    assign w_step_idx    = (r_state == RECALL) ? (r_lap_idx + 1'b1) : '0;
    assign w_rd_addr     = r_rd_base + w_step_idx;

    lap_regfile #(
        .TIME_W (TIME_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (w_capture),
        .wr_addr (r_wr_ptr),
        .wr_data (time_in),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge state_reset) begin
        if (state_reset) begin
            r_state     <= LIVE;
            r_wr_ptr    <= '0;
            r_rd_base   <= '0;
            r_lap_count <= '0;
            r_hold_cnt  <= '0;
            r_disp_data <= '0;
            r_disp_sel  <= 1'b0;
            r_lap_idx   <= '0;
            r_full      <= 1'b0;
            r_recall_d  <= 1'b0;
        end else if (rst) begin
            r_state     <= LIVE;
            r_wr_ptr    <= '0;
            r_rd_base   <= '0;
            r_lap_count <= '0;
            r_hold_cnt  <= '0;
            r_disp_data <= '0;
            r_disp_sel  <= 1'b0;
            r_lap_idx   <= '0;
            r_full      <= 1'b0;
            r_recall_d  <= 1'b0;
        end else begin
            r_recall_d <= recall_btn;

            // Once full, each new lap overwrites the oldest and slides the window.
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_full) begin
                    r_rd_base <= r_rd_base + 1'b1;
                end else begin
                    r_lap_count <= r_lap_count + 1'b1;
                    r_full      <= (r_lap_count == c_cnt_last);
                end
            end

            case (r_state)
                LIVE: begin
                    if (w_capture) begin
                        r_state     <= HOLD;
                        r_hold_cnt  <= c_hold_load;
                        r_disp_data <= time_in;
                        r_disp_sel  <= 1'b1;
                        r_lap_idx   <= w_newest_idx;
                    end else if (w_recall_go) begin
                        r_state     <= RECALL;
                        r_disp_data <= w_rd_data;
                        r_disp_sel  <= 1'b1;
                        r_lap_idx   <= '0;
                    end else begin
                        r_disp_data <= time_in;
                        r_disp_sel  <= 1'b0;
                        r_lap_idx   <= '0;
                    end
                end

                HOLD: begin
                    if (w_capture) begin
                        r_hold_cnt  <= c_hold_load;
                        r_disp_data <= time_in;
                        r_disp_sel  <= 1'b1;
                        r_lap_idx   <= w_newest_idx;
                    end else if (mode || (r_hold_cnt == '0)) begin
                        r_state     <= LIVE;
                        r_disp_data <= time_in;
                        r_disp_sel  <= 1'b0;
                        r_lap_idx   <= '0;
                    end else begin
                        r_hold_cnt  <= r_hold_cnt - 1'b1;
                    end
                end

                RECALL: begin
                    if (clken || mode || (w_recall_edge && w_idx_is_last)) begin
                        r_state     <= LIVE;
                        r_disp_data <= time_in;
                        r_disp_sel  <= 1'b0;
                        r_lap_idx   <= '0;
                    end else if (w_recall_edge) begin
                        r_lap_idx   <= r_lap_idx + 1'b1;
                        r_disp_data <= w_rd_data;
                    end
                end

                default: begin
                    r_state     <= LIVE;
                    r_disp_data <= time_in;
                    r_disp_sel  <= 1'b0;
                    r_lap_idx   <= '0;
                end
            endcase
        end
    end

    assign disp_data = r_disp_data;
    assign disp_sel  = r_disp_sel;
    assign lap_idx   = r_lap_idx;
    assign lap_count = r_lap_count;
    assign full      = r_full;

endmodule

`default_nettype wire

// File: tb/tb_lap_recall_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_lap_recall_ctrl
// Brief   : Directed plus random stimulus against a queue-based lap model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_lap_recall_ctrl;

    localparam int TIME_W   = 20;
    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int HOLD_CYC = 16;

    logic              clk = 1'b0;
    logic              state_reset;
    logic              rst;
    logic              clken;
    logic              mode;
    logic              lap_trigger;
    logic              recall_btn;
    logic [TIME_W-1:0] time_in;
    logic [TIME_W-1:0] disp_data;
    logic              disp_sel;
    logic [AW-1:0]     lap_idx;
    logic [AW:0]       lap_count;
    logic              full;

    int total = 0;
    int bad   = 0;

    lap_recall_ctrl #(
        .TIME_W   (TIME_W),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .clk         (clk),
        .state_reset (state_reset),
        .rst         (rst),
        .clken       (clken),
        .mode        (mode),
        .lap_trigger (lap_trigger),
        .recall_btn  (recall_btn),
        .time_in     (time_in),
        .disp_data   (disp_data),
        .disp_sel    (disp_sel),
        .lap_idx     (lap_idx),
        .lap_count   (lap_count),
        .full        (full)
    );

    always #5 clk = ~clk;

    // Reference model: a bounded queue of laps, oldest at the front.
    logic [TIME_W-1:0] laps[$];
    bit                m_hold;
    bit                m_recall;
    int                m_left;
    int                m_pos;
    bit                m_btn_d;
    logic [TIME_W-1:0] e_data;
    bit                e_sel;
    int                e_idx;

    task automatic model_reset();
        laps.delete();
        m_hold = 0; m_recall = 0; m_left = 0; m_pos = 0; m_btn_d = 0;
        e_data = '0; e_sel = 0; e_idx = 0;
    endtask

    task automatic go_live();
        m_hold = 0; m_recall = 0;
        e_data = time_in; e_sel = 0; e_idx = 0;
    endtask

    task automatic model_step();
        bit redge;
        bit cap;
        if (state_reset || rst) begin
            model_reset();
        end else begin
            redge   = recall_btn && !m_btn_d;
            m_btn_d = recall_btn;
            cap     = lap_trigger && clken && !mode && !m_recall;
            if (cap) begin
                if (laps.size() == DEPTH) void'(laps.pop_front());
                laps.push_back(time_in);
                m_hold = 1; m_recall = 0; m_left = HOLD_CYC - 1;
                e_data = time_in; e_sel = 1; e_idx = laps.size() - 1;
            end else if (m_hold) begin
                if (mode || m_left == 0) go_live();
                else m_left--;
            end else if (m_recall) begin
                if (clken || mode) go_live();
                else if (redge) begin
                    if (m_pos == laps.size() - 1) go_live();
                    else begin
                        m_pos++;
                        e_idx = m_pos; e_data = laps[m_pos];
                    end
                end
            end else begin
                if (redge && !clken && !mode && laps.size() > 0) begin
                    m_recall = 1; m_pos = 0;
                    e_idx = 0; e_data = laps[0]; e_sel = 1;
                end else go_live();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".disp_data"}, 32'(disp_data), 32'(e_data));
        chk({where, ".disp_sel"},  32'(disp_sel),  32'(e_sel));
        chk({where, ".lap_idx"},   32'(lap_idx),   32'(e_idx));
        chk({where, ".lap_count"}, 32'(lap_count), 32'(laps.size()));
        chk({where, ".full"},      32'(full),      32'(laps.size() == DEPTH));
    endtask

    task automatic cycle(input string where);
        @(posedge clk);
        model_step();
        #1;
        check_all(where);
    endtask

    task automatic idle(input int n, input string where);
        for (int i = 0; i < n; i++) begin
            time_in = TIME_W'($urandom);
            cycle(where);
        end
    endtask

    task automatic press(input string where);
        recall_btn = 1'b1;
        cycle(where);
        recall_btn = 1'b0;
        cycle(where);
    endtask

    initial begin
        int sel_cycles;
        bit data_ok;

        state_reset = 1'b1; rst = 1'b0; clken = 1'b0; mode = 1'b0;
        lap_trigger = 1'b0; recall_btn = 1'b0; time_in = 20'h00000;
        model_reset();
        #2;
        check_all("por");
        cycle("por");
        state_reset = 1'b0;
        time_in = 20'h00042;
        cycle("track");
        chk("track_latency", 32'(disp_data), 32'h42);

        // Single lap: display frozen for HOLD_CYC cycles.
        clken = 1'b1; time_in = 20'h01234; lap_trigger = 1'b1;
        cycle("single");
        lap_trigger = 1'b0;
        sel_cycles = int'(disp_sel);
        data_ok = (disp_data == 20'h01234);
        for (int i = 0; i < 20; i++) begin
            time_in = TIME_W'($urandom);
            cycle("single");
            if (disp_sel) begin
                sel_cycles++;
                if (disp_data != 20'h01234) data_ok = 0;
            end
        end
        chk("single_hold_len", 32'(sel_cycles), 32'(HOLD_CYC));
        chk("single_hold_data", 32'(data_ok), 32'd1);

        // Async reset in the middle of HOLD takes effect without a clock.
        time_in = 20'h00777; lap_trigger = 1'b1;
        cycle("mid_hold");
        lap_trigger = 1'b0;
        idle(5, "mid_hold");
        state_reset = 1'b1;
        #2;
        model_reset();
        check_all("areset");
        chk("areset_sel", 32'(disp_sel), 32'd0);
        cycle("areset");
        state_reset = 1'b0;
        time_in = 20'h00999;
        cycle("after_areset");

        // Wrap: nine captures into an eight-entry buffer.
        for (int v = 1; v <= 9; v++) begin
            time_in = TIME_W'(v); lap_trigger = 1'b1;
            cycle("wrap_cap");
        end
        lap_trigger = 1'b0;
        idle(20, "wrap_wait");
        chk("wrap_full", 32'(full), 32'd1);
        clken = 1'b0;
        cycle("wrap_stop");
        for (int i = 0; i < 8; i++) begin
            recall_btn = 1'b1;
            cycle("wrap_recall");
            chk("wrap_recall_data", 32'(disp_data), 32'(i + 2));
            chk("wrap_recall_idx", 32'(lap_idx), 32'(i));
            recall_btn = 1'b0;
            cycle("wrap_recall");
        end
        recall_btn = 1'b1;
        cycle("wrap_exit");
        chk("wrap_exit_sel", 32'(disp_sel), 32'd0);
        recall_btn = 1'b0;
        cycle("wrap_exit");

        // Collision: capture wins over the recall edge.
        clken = 1'b1;
        cycle("collide");
        time_in = 20'h0abcd; lap_trigger = 1'b1; recall_btn = 1'b1;
        cycle("collide");
        chk("collide_data", 32'(disp_data), 32'h0abcd);
        lap_trigger = 1'b0; recall_btn = 1'b0;
        idle(20, "collide_wait");

        // Gating by clock mode, then RECALL aborted by clken.
        rst = 1'b1;
        cycle("gate_clr");
        rst = 1'b0; mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clken = i[0];
            lap_trigger = 1'b1; recall_btn = 1'b1;
            cycle("gate");
            lap_trigger = 1'b0; recall_btn = 1'b0;
            cycle("gate");
        end
        chk("gate_count", 32'(lap_count), 32'd0);
        chk("gate_sel", 32'(disp_sel), 32'd0);
        mode = 1'b0; clken = 1'b1; time_in = 20'h00321; lap_trigger = 1'b1;
        cycle("gate_cap");
        lap_trigger = 1'b0;
        idle(20, "gate_wait");
        clken = 1'b0;
        cycle("gate_stop");
        press("gate_recall");
        chk("gate_recall_sel", 32'(disp_sel), 32'd1);
        clken = 1'b1;
        cycle("gate_abort");
        chk("gate_abort_sel", 32'(disp_sel), 32'd0);

        // Sync clear from RECALL with five laps stored.
        rst = 1'b1;
        cycle("sclr");
        rst = 1'b0;
        for (int v = 0; v < 5; v++) begin
            time_in = TIME_W'($urandom); lap_trigger = 1'b1;
            cycle("sclr_cap");
        end
        lap_trigger = 1'b0;
        idle(20, "sclr_wait");
        clken = 1'b0;
        cycle("sclr_stop");
        press("sclr_recall");
        chk("sclr_count5", 32'(lap_count), 32'd5);
        rst = 1'b1;
        cycle("sclr_hit");
        chk("sclr_count0", 32'(lap_count), 32'd0);
        rst = 1'b0;
        press("sclr_ignored");
        chk("sclr_ignored_sel", 32'(disp_sel), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            lap_trigger = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) clken = ~clken;
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            if ($urandom_range(0, 2) == 0) recall_btn = ~recall_btn;
            time_in = TIME_W'($urandom);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
